// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and constants for the debounce_edge block.
//   state_e           FSM state encoding (IDLE_LOW, CHK_HIGH, IDLE_HIGH, CHK_LOW)
//   GLITCH_CNT_W      width of the saturating glitch counter
//   CNT_W             width of the stability counter
//   DEF_SYNC_STAGES   default synchronizer depth
//   DEF_STABLE_CYCLES default number of stable cycles to accept a new level
package debounce_pkg;

  localparam int GLITCH_CNT_W      = 8;
  localparam int CNT_W             = 8;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } state_e;

  // The debounced level is high while settled high or while checking a fall.
  function automatic logic state_level(input state_e s);
    return (s == IDLE_HIGH) || (s == CHK_LOW);
  endfunction

endpackage

// File: rtl/debounce_edge_sync_chain.sv
// sync_chain: STAGES-deep flop chain that brings an asynchronous level into
// the clk domain. Synchronous active-high reset clears every stage.
//   clk    input  clock
//   reset  input  synchronous active-high reset
//   d_i    input  asynchronous level
//   q_o    output last synchronizer stage
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// debounce_edge: synchronizes and debounces a bouncy level input, produces
// edge pulses on accepted transitions and counts aborted transitions.
//   clk           input  clock, all state on rising edge
//   reset         input  synchronous active-high reset
//   d_i           input  raw asynchronous / bouncy level
//   level_o       output debounced level (decoded from the state register)
//   rise_o        output one-cycle pulse on an accepted 0->1 transition
//   fall_o        output one-cycle pulse on an accepted 1->0 transition
//   glitch_cnt_o  output saturating count of aborted transitions
// Build option: define DEBOUNCE_EDGE_PULSE_EN to include the rise/fall pulse
// logic; without it rise_o and fall_o are tied low.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE_LOW  | settled low, waiting for sync to go high
// CHK_HIGH  | sync high, counting towards accepting a rise
// IDLE_HIGH | settled high, waiting for sync to go low
// CHK_LOW   | sync low, counting towards accepting a fall
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    d_i,
  output logic                    level_o,
  output logic                    rise_o,
  output logic                    fall_o,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt_o
);

  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_MAX = '1;

  logic sync;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [GLITCH_CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;
  logic                    glitch;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (d_i),
    .q_o   (sync)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    glitch  = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (sync) begin
          state_d = CHK_HIGH;
          count_d = CNT_W'(1);
        end else begin
          count_d = '0;
        end
      end
      CHK_HIGH: begin
        if (sync) begin
          if (count_q == CNT_LAST) begin
            state_d = IDLE_HIGH;
            count_d = '0;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end else begin
          state_d = IDLE_LOW;
          count_d = '0;
          glitch  = 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!sync) begin
          state_d = CHK_LOW;
          count_d = CNT_W'(1);
        end else begin
          count_d = '0;
        end
      end
      CHK_LOW: begin
        if (!sync) begin
          if (count_q == CNT_LAST) begin
            state_d = IDLE_LOW;
            count_d = '0;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end else begin
          state_d = IDLE_HIGH;
          count_d = '0;
          glitch  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (glitch && (glitch_cnt_q != GLITCH_MAX)) begin
      glitch_cnt_d = glitch_cnt_q + GLITCH_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE_LOW;
      count_q      <= '0;
      glitch_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign level_o      = state_level(state_q);
  assign glitch_cnt_o = glitch_cnt_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  // Pulses are registered on the same edge that completes the transition,
  // so they are high for the first cycle of the new level.
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    rise_d = (state_q == CHK_HIGH) && (state_d == IDLE_HIGH);
    fall_d = (state_q == CHK_LOW)  && (state_d == IDLE_LOW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_edge.sv
module tb_debounce_edge;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int LAT    = SYNC + STABLE;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  typedef struct packed {
    logic       level;
    logic       rise;
    logic       fall;
    logic [7:0] glitch;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_i;
  logic       level_o;
  logic       rise_o;
  logic       fall_o;
  logic [7:0] glitch_cnt_o;

  int checks   = 0;
  int failures = 0;

  exp_t exp_q[$];

  // Reference model: run-length of synchronized samples disagreeing with
  // the accepted level.
  logic [SYNC-1:0] m_sync;
  logic            m_level;
  int              m_run;
  int              m_glitch;
  logic            m_rise, m_fall;

  int rise_seen, fall_seen;

  always #5 clk = ~clk;

  debounce_edge #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .d_i          (d_i),
    .level_o      (level_o),
    .rise_o       (rise_o),
    .fall_o       (fall_o),
    .glitch_cnt_o (glitch_cnt_o)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic d, input logic r);
    logic s;
    exp_t e;
    s = m_sync[SYNC-1];
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (r) begin
      m_sync = '0; m_level = 1'b0; m_run = 0; m_glitch = 0;
    end else begin
      if (s != m_level) begin
        m_run++;
        if (m_run == STABLE) begin
          m_level = s;
          m_run   = 0;
          m_rise  = PULSE_EN & s;
          m_fall  = PULSE_EN & ~s;
        end
      end else begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end
      m_sync = {m_sync[SYNC-2:0], d};
    end
    e.level  = m_level;
    e.rise   = m_rise;
    e.fall   = m_fall;
    e.glitch = 8'(m_glitch);
    exp_q.push_back(e);
  endtask

  // One clock: drive inputs, model the edge, compare half a cycle later.
  task automatic cycle(input logic d, input logic r);
    exp_t e;
    d_i   = d;
    reset = r;
    @(posedge clk);
    model_edge(d, r);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check_eq("level",  level_o,      e.level);
      check_eq("rise",   rise_o,       e.rise);
      check_eq("fall",   fall_o,       e.fall);
      check_eq("glitch", glitch_cnt_o, e.glitch);
      check_eq("rise_fall_excl", rise_o & fall_o, 0);
    end
    if (rise_o) rise_seen++;
    if (fall_o) fall_seen++;
  endtask

  // Holds d and returns the edge index (from 1) at which level_o first
  // equals target; -1 if it never does within the budget.
  task automatic hold_until(input logic d, input logic target, input int budget,
                            output int edge_idx);
    edge_idx = -1;
    for (int i = 1; i <= budget; i++) begin
      cycle(d, 1'b0);
      if (edge_idx < 0 && level_o == target) edge_idx = i;
    end
  endtask

  initial begin
    int e_idx;
    m_sync = '0; m_level = 1'b0; m_run = 0; m_glitch = 0;
    d_i   = 1'b0;
    reset = 1'b1;

    // Reset state
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    check_eq("reset_level",  level_o, 0);
    check_eq("reset_glitch", glitch_cnt_o, 0);

    // Rise latency and single pulse
    rise_seen = 0;
    hold_until(1'b1, 1'b1, 12, e_idx);
    check_eq("rise_latency", e_idx, LAT);
    check_eq("rise_pulses", rise_seen, PULSE_EN ? 1 : 0);
    check_eq("rise_glitch", glitch_cnt_o, 0);

    // Fall latency and single pulse
    fall_seen = 0;
    hold_until(1'b0, 1'b0, 12, e_idx);
    check_eq("fall_latency", e_idx, LAT);
    check_eq("fall_pulses", fall_seen, PULSE_EN ? 1 : 0);

    // Two-cycle bounce from IDLE_LOW is rejected
    rise_seen = 0; fall_seen = 0;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0);
    check_eq("bounce_level",  level_o, 0);
    check_eq("bounce_glitch", glitch_cnt_o, 1);
    check_eq("bounce_pulses", rise_seen + fall_seen, 0);

    // 300 single-cycle pulses saturate the glitch counter
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
    check_eq("sat_glitch", glitch_cnt_o, 255);
    check_eq("sat_level",  level_o, 0);

    // Reset while counting a rise (count=3 after edge 5)
    cycle(1'b0, 1'b1);
    rise_seen = 0;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
    check_eq("midchk_level", level_o, 0);
    cycle(1'b1, 1'b1);
    check_eq("midchk_rst_level",  level_o, 0);
    check_eq("midchk_rst_rise",   rise_o, 0);
    check_eq("midchk_rst_glitch", glitch_cnt_o, 0);
    check_eq("midchk_no_pulse",   rise_seen, 0);
    hold_until(1'b1, 1'b1, 12, e_idx);
    check_eq("reacq_latency", e_idx, LAT);
    check_eq("reacq_glitch", glitch_cnt_o, 0);

    // Random bouncy input with occasional resets
    for (int i = 0; i < 600; i++) begin
      logic d, r;
      d = ($urandom_range(0, 3) != 0) ? d_i : ~d_i;
      if ((i / 40) % 2 == 1) d = ($urandom_range(0, 9) == 0) ? ~d_i : d_i;
      r = ($urandom_range(0, 150) == 0);
      cycle(d, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/debounce_edge.md
DEBOUNCE_EDGE -- requirements
Module: debounce_edge

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on d_i (legal 2..4).
REQ-002 Parameter STABLE_CYCLES, default 4, consecutive disagreeing cycles required to accept a new level (legal 2..255).
REQ-003 Port clk input 1: single clock; all state updates on its rising edge.
REQ-004 Port reset input 1: synchronous, active-high reset.
REQ-005 Port d_i input 1: raw asynchronous or bouncy level input.
REQ-006 Port level_o output 1: debounced level, registered.
REQ-007 Port rise_o output 1: one-cycle pulse on accepted 0->1 transition.
REQ-008 Port fall_o output 1: one-cycle pulse on accepted 1->0 transition.
REQ-009 Port glitch_cnt_o output 8: saturating count of aborted transitions.

Function
REQ-010 d_i SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (sync) feeds the remaining logic.
REQ-011 FSM states SHALL be IDLE_LOW, CHK_HIGH, IDLE_HIGH, CHK_LOW; level_o = 1 exactly in IDLE_HIGH and CHK_LOW.
REQ-012 IDLE_LOW: sync=1 -> CHK_HIGH with count=1; else remain, count=0.
REQ-013 CHK_HIGH: sync=1 and count=STABLE_CYCLES-1 -> IDLE_HIGH, count=0; sync=1 otherwise -> count+1; sync=0 -> IDLE_LOW, count=0, glitch event.
REQ-014 IDLE_HIGH/CHK_LOW SHALL mirror REQ-012/013 with polarity inverted.
REQ-015 Counter SHALL be 8 bits, never exceeding STABLE_CYCLES-1.
REQ-016 Latency: d_i held 1 from edge 1 (first sampling edge) SHALL set level_o after edge SYNC_STAGES+STABLE_CYCLES; falls symmetric.
REQ-017 rise_o SHALL be 1 for exactly the cycle following the edge where level_o becomes 1; fall_o likewise for 0; never both high.
REQ-018 glitch_cnt_o SHALL increment by 1 on each glitch event and saturate at 255 (no wrap).
REQ-019 A bounce shorter than STABLE_CYCLES synchronized cycles SHALL leave level_o, rise_o, fall_o unchanged.

Reset
REQ-020 reset sampled high SHALL on that edge clear sync chain, count, glitch_cnt_o, level_o, rise_o, fall_o to 0 and FSM to IDLE_LOW.
REQ-021 reset SHALL override all other activity, including a transition completing the same edge (no pulse emitted).
REQ-022 Reset mid-CHK state SHALL discard partial count without glitch increment; after release with d_i=1, full REQ-016 latency applies.

Configuration
REQ-023 Macro DEBOUNCE_EDGE_PULSE_EN defined: rise_o/fall_o behave per REQ-017.
REQ-024 Macro undefined: pulse logic SHALL be absent and rise_o, fall_o tied to 0; ports remain present; all other behaviour identical.

Structure
REQ-025 Package debounce_pkg SHALL hold the FSM state enum, GLITCH_CNT_W=8 and default parameter constants.
REQ-026 The synchronizer SHALL be sub-module sync_chain (parameter STAGES, ports clk, reset, d_i, q_o), synchronous active-high reset.
REQ-027 Total RTL 120-400 lines; no latches, no asynchronous reset.

Verification
REQ-028 Defaults, d_i 0->1 held: level_o=1 after edge 6, rise_o=1 for exactly edge 7 cycle, glitch_cnt_o=0.
REQ-029 d_i high for 2 cycles then low (from IDLE_LOW): level_o stays 0, no pulses, glitch_cnt_o=1.
REQ-030 300 short pulses of 1 cycle each: glitch_cnt_o=255, level_o=0.
REQ-031 level_o=1, d_i drops and held 0: level_o=0 after 6 edges, fall_o single pulse.
REQ-032 reset asserted during CHK_HIGH count=3: all outputs 0 next edge, glitch_cnt_o unchanged at 0, re-acquire takes full 6 edges.
REQ-033 Build without DEBOUNCE_EDGE_PULSE_EN, rerun REQ-028: level_o timing identical, rise_o/fall_o constantly 0.
